// File: rtl/nios_sd_loader_timeout_sched.sv
// Round-robin one-shot timeout scheduler sharing a single interval timer among NUM_REQ requesters.
// Outputs are registered from the next-state decode, so each slave write appears in its own state's cycle.
module nios_sd_loader_timeout_sched #(
  parameter int NUM_REQ = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_REQ-1:0]    req_i,
  input  logic [32*NUM_REQ-1:0] ticks_i,
  output logic [NUM_REQ-1:0]    grant_o,
  output logic [NUM_REQ-1:0]    done_o,
  output logic                  busy_o,
  output logic [2:0]            tmr_address_o,
  output logic                  tmr_chipselect_o,
  output logic                  tmr_write_n_o,
  output logic [15:0]           tmr_writedata_o,
  input  logic                  tmr_irq_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam logic [IW-1:0] PTR_RST = IW'(NUM_REQ - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_PL, S_WR_PH, S_GAP, S_WR_CTL, S_WAIT, S_CLR, S_DONE, S_AB_STOP, S_AB_CLR
  } state_t;

  state_t             r_state, w_next;
  logic [IW-1:0]      r_ptr, r_own, w_ptr, w_own, w_win, w_idx;
  logic [15:0]        r_phi, w_phi;
  logic               r_zero, w_zero, w_any;
  logic [NUM_REQ-1:0] r_grant, r_done, w_grant, w_done;
  logic               r_busy, r_cs, r_wn, w_cs;
  logic [2:0]         r_addr, w_addr;
  logic [15:0]        r_wdat, w_wdat;
  logic [31:0]        w_ticks, w_tm1;
  logic [31:0]        w_tk [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_tk
    assign w_tk[g] = ticks_i[32*g +: 32];
  end

  // Search starts one past the last winner; lowest offset wins, so iterate from the far end.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    w_idx = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      w_idx = IW'((int'(r_ptr) + i) % NUM_REQ);
      if (req_i[w_idx]) begin
        w_any = 1'b1;
        w_win = w_idx;
      end
    end
  end

  assign w_ticks = w_tk[w_win];
  assign w_tm1   = w_ticks - 32'd1;

  always_comb begin
    w_next  = r_state;
    w_own   = r_own;
    w_ptr   = r_ptr;
    w_phi   = r_phi;
    w_zero  = r_zero;
    w_grant = '0;
    w_done  = '0;
    w_cs    = 1'b0;
    w_addr  = '0;
    w_wdat  = '0;
    case (r_state)
      S_IDLE: if (w_any) begin
        w_own          = w_win;
        w_ptr          = w_win;
        w_phi          = w_tm1[31:16];
        w_grant[w_win] = 1'b1;
        if (w_ticks == 32'd0) begin
          w_next = S_DONE;
          w_zero = 1'b1;
        end else begin
          w_next = S_WR_PL;
          w_cs   = 1'b1;
          w_addr = 3'd2;
          w_wdat = w_tm1[15:0];
        end
      end
      S_WR_PL: begin
        w_next         = S_WR_PH;
        w_grant[r_own] = 1'b1;
        w_cs           = 1'b1;
        w_addr         = 3'd3;
        w_wdat         = r_phi;
      end
      S_WR_PH: begin
        w_next         = S_GAP;
        w_grant[r_own] = 1'b1;
      end
      S_GAP: begin
        w_next         = S_WR_CTL;
        w_grant[r_own] = 1'b1;
        w_cs           = 1'b1;
        w_addr         = 3'd1;
        w_wdat         = 16'h0005;
      end
      S_WR_CTL: begin
        w_next         = S_WAIT;
        w_grant[r_own] = 1'b1;
      end
      S_WAIT: begin
        w_grant[r_own] = 1'b1;
        if (tmr_irq_i) begin
          w_next = S_CLR;
          w_cs   = 1'b1;
        end else if (!req_i[r_own]) begin
          w_next = S_AB_STOP;
          w_cs   = 1'b1;
          w_addr = 3'd1;
          w_wdat = 16'h0008;
        end
      end
      S_CLR: begin
        w_next        = S_DONE;
        w_done[r_own] = 1'b1;
      end
      // A zero-length request lingers one extra cycle in DONE so its pulse lands in cycle 2.
      S_DONE: begin
        if (r_zero) begin
          w_zero        = 1'b0;
          w_done[r_own] = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_AB_STOP: begin
        w_next         = S_AB_CLR;
        w_grant[r_own] = 1'b1;
        w_cs           = 1'b1;
      end
      S_AB_CLR: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ptr   <= PTR_RST;
      r_own   <= '0;
      r_phi   <= '0;
      r_zero  <= 1'b0;
      r_grant <= '0;
      r_done  <= '0;
      r_busy  <= 1'b0;
      r_cs    <= 1'b0;
      r_wn    <= 1'b1;
      r_addr  <= '0;
      r_wdat  <= '0;
    end else begin
      r_state <= w_next;
      r_ptr   <= w_ptr;
      r_own   <= w_own;
      r_phi   <= w_phi;
      r_zero  <= w_zero;
      r_grant <= w_grant;
      r_done  <= w_done;
      r_busy  <= (w_next != S_IDLE);
      r_cs    <= w_cs;
      r_wn    <= ~w_cs;
      r_addr  <= w_addr;
      r_wdat  <= w_wdat;
    end
  end

  assign grant_o          = r_grant;
  assign done_o           = r_done;
  assign busy_o           = r_busy;
  assign tmr_chipselect_o = r_cs;
  assign tmr_write_n_o    = r_wn;
  assign tmr_address_o    = r_addr;
  assign tmr_writedata_o  = r_wdat;
endmodule

// File: tb/tb_nios_sd_loader_timeout_sched.sv
// Bench for nios_sd_loader_timeout_sched: timeline model of each grant plus a behavioural interval timer,
// checked every cycle, with directed literal expectations at the key cycles.
module tb_nios_sd_loader_timeout_sched;
  localparam int N = 4;

  logic           clk, reset_n;
  logic [N-1:0]   req_i, grant_o, done_o;
  logic [32*N-1:0] ticks_i;
  logic           busy_o, tmr_chipselect_o, tmr_write_n_o, tmr_irq_i;
  logic [2:0]     tmr_address_o;
  logic [15:0]    tmr_writedata_o;
  logic           tm_irq, irq_nxt, force_irq;
  int             cyc = 0;
  int             n_vec = 0;
  int             n_err = 0;

  nios_sd_loader_timeout_sched #(.NUM_REQ(N)) dut (
    .clk(clk), .reset_n(reset_n), .req_i(req_i), .ticks_i(ticks_i),
    .grant_o(grant_o), .done_o(done_o), .busy_o(busy_o),
    .tmr_address_o(tmr_address_o), .tmr_chipselect_o(tmr_chipselect_o),
    .tmr_write_n_o(tmr_write_n_o), .tmr_writedata_o(tmr_writedata_o),
    .tmr_irq_i(tmr_irq_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  assign tmr_irq_i = tm_irq | force_irq;

  initial begin
    tm_irq = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tm_irq = irq_nxt;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach its end (cycle %0d)", cyc);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] bus();
    return 32'({tmr_chipselect_o, tmr_write_n_o, tmr_address_o, tmr_writedata_o});
  endfunction

  task automatic chk_wr(input string nm, input logic [2:0] a, input logic [15:0] d);
    chk(nm, bus(), 32'({1'b1, 1'b0, a, d}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic to_neg(input int c);
    while (cyc < c) tick();
    @(negedge clk);
  endtask

  task automatic start(input int k, input logic [31:0] t, output int s);
    tick();
    ticks_i[32*k +: 32] = t;
    req_i[k] = 1'b1;
    s = cyc;
  endtask

  // Grant timeline model: relative cycle k after the IDLE sample fixes every output.
  bit          m_act, m_abort, found;
  int          m_ptr, m_s, m_own, m_end, m_ev, k;
  logic [31:0] m_T, m_tm1;
  logic [N-1:0] e_g, e_d;
  logic        e_b, e_cs;
  logic [2:0]  e_a;
  logic [15:0] e_w;
  bit          t_run, t_to, t_ito;
  logic [31:0] t_per;
  int          t_dl;

  always @(negedge clk) begin
    e_g = '0; e_d = '0; e_b = 1'b0; e_cs = 1'b0; e_a = '0; e_w = '0;
    if (reset_n && m_act) begin
      k = cyc - m_s;
      e_b = 1'b1;
      e_g[m_own] = 1'b1;
      if (m_T == 0) begin
        if (k == 2) begin e_g = '0; e_d[m_own] = 1'b1; end
      end else begin
        m_tm1 = m_T - 32'd1;
        if (k == 1) begin e_cs = 1'b1; e_a = 3'd2; e_w = m_tm1[15:0]; end
        if (k == 2) begin e_cs = 1'b1; e_a = 3'd3; e_w = m_tm1[31:16]; end
        if (k == 4) begin e_cs = 1'b1; e_a = 3'd1; e_w = 16'h0005; end
        if (m_end >= 0 && cyc == m_ev + 1) begin
          e_cs = 1'b1;
          e_a  = m_abort ? 3'd1 : 3'd0;
          e_w  = m_abort ? 16'h0008 : 16'h0000;
        end
        if (m_end >= 0 && cyc == m_ev + 2) begin
          if (m_abort) begin e_cs = 1'b1; e_a = 3'd0; e_w = 16'h0000; end
          else begin e_g = '0; e_d[m_own] = 1'b1; end
        end
      end
    end
    chk("cycle_model",
        32'({grant_o, done_o, busy_o, tmr_chipselect_o, tmr_write_n_o, tmr_address_o, tmr_writedata_o}),
        32'({e_g, e_d, e_b, e_cs, ~e_cs, e_a, e_w}));

    if (!reset_n) begin
      m_act = 1'b0;
      m_ptr = N - 1;
    end else begin
      if (!m_act) begin
        found = 1'b0;
        for (int i = 1; i <= N; i++)
          if (!found && req_i[(m_ptr + i) % N]) begin
            found = 1'b1;
            m_own = (m_ptr + i) % N;
          end
        if (found) begin
          m_ptr = m_own;
          m_act = 1'b1;
          m_s   = cyc;
          m_T   = ticks_i[32*m_own +: 32];
          m_end = (m_T == 0) ? cyc + 3 : -1;
        end
      end else if (m_T != 0 && m_end < 0 && cyc - m_s >= 5) begin
        if (tmr_irq_i) begin
          m_end = cyc + 3; m_ev = cyc; m_abort = 1'b0;
        end else if (!req_i[m_own]) begin
          m_end = cyc + 3; m_ev = cyc; m_abort = 1'b1;
        end
      end
      if (m_act && m_end >= 0 && cyc + 1 == m_end) m_act = 1'b0;
    end

    // Interval timer: period P fires P+1 cycles after the START write takes effect.
    if (!reset_n) begin
      t_run = 1'b0; t_to = 1'b0; t_ito = 1'b0; t_per = '0; irq_nxt = 1'b0;
    end else begin
      if (tmr_chipselect_o && !tmr_write_n_o) begin
        case (tmr_address_o)
          3'd0: t_to = 1'b0;
          3'd1: begin
            t_ito = tmr_writedata_o[0];
            if (tmr_writedata_o[3]) t_run = 1'b0;
            if (tmr_writedata_o[2]) begin t_run = 1'b1; t_dl = cyc + int'(t_per) + 2; end
          end
          3'd2: begin t_per[15:0] = tmr_writedata_o; t_run = 1'b0; end
          3'd3: begin t_per[31:16] = tmr_writedata_o; t_run = 1'b0; end
          default: ;
        endcase
      end
      if (t_run && cyc + 1 == t_dl) begin t_to = 1'b1; t_run = 1'b0; end
      irq_nxt = t_to & t_ito;
    end
  end

  initial begin
    int s;
    reset_n = 1'b0; req_i = '0; ticks_i = '0; force_irq = 1'b0;
    to_neg(2);
    chk("reset_outputs", 32'({grant_o, done_o, busy_o, tmr_chipselect_o, tmr_write_n_o, tmr_address_o, tmr_writedata_o}),
        32'({4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 3'b0, 16'h0}));
    tick();
    reset_n = 1'b1;

    // Contention 0 and 2, T=10 each
    tick();
    ticks_i[31:0] = 32'd10; ticks_i[95:64] = 32'd10; req_i = 4'b0101; s = cyc;
    to_neg(s + 1);  chk("rr_grant_a", 32'(grant_o), 32'h1);
    to_neg(s + 17); chk("rr_done_a",  32'(done_o),  32'h1);
    to_neg(s + 19); chk("rr_grant_b", 32'(grant_o), 32'h4);
    to_neg(s + 35); chk("rr_done_b",  32'(done_o),  32'h4);
    to_neg(s + 37); chk("rr_grant_c", 32'(grant_o), 32'h1);
    to_neg(s + 53); chk("rr_done_c",  32'(done_o),  32'h1);
    to_neg(s + 55); chk("rr_grant_d", 32'(grant_o), 32'h4);
    to_neg(s + 71); chk("rr_done_d",  32'(done_o),  32'h4);
    tick(); req_i = '0;

    // Single request T=100; ticks change mid-run must not matter
    start(0, 32'd100, s);
    to_neg(s + 1); chk_wr("pl_write", 3'd2, 16'h0063); chk("single_grant", 32'(grant_o), 32'h1);
    to_neg(s + 2); chk_wr("ph_write", 3'd3, 16'h0000);
    tick(); ticks_i[31:0] = 32'd5;
    to_neg(s + 4);   chk_wr("ctl_write", 3'd1, 16'h0005);
    to_neg(s + 104); chk("irq_low_before", 32'(tmr_irq_i), 32'h0);
    to_neg(s + 105); chk("irq_rise", 32'(tmr_irq_i), 32'h1);
    to_neg(s + 106); chk_wr("clr_write", 3'd0, 16'h0000);
    to_neg(s + 107); chk("single_done", 32'(done_o), 32'h1); chk("grant_drop", 32'(grant_o), 32'h0);
    tick(); req_i = '0;

    // T=0 on requester 3
    start(3, 32'd0, s);
    to_neg(s + 1); chk("t0_grant", 32'(grant_o), 32'h8); chk("t0_nowrite", 32'(tmr_chipselect_o), 32'h0);
    to_neg(s + 2); chk("t0_done", 32'(done_o), 32'h8);
    tick(); req_i = '0;
    @(negedge clk); chk("t0_idle", 32'(busy_o), 32'h0);

    // Abort at cycle 50
    start(1, 32'd1000, s);
    to_neg(s + 49);
    tick(); req_i = '0;
    to_neg(s + 51); chk_wr("abort_stop", 3'd1, 16'h0008);
    to_neg(s + 52); chk_wr("abort_clr", 3'd0, 16'h0000); chk("abort_grant", 32'(grant_o), 32'h2);
    to_neg(s + 53); chk("abort_idle", 32'(busy_o), 32'h0); chk("abort_nodone", 32'(done_o), 32'h0);
    chk("abort_noirq", 32'(tmr_irq_i), 32'h0);

    // Forced irq with simultaneous drop: irq wins
    start(2, 32'd1000, s);
    to_neg(s + 19);
    tick(); force_irq = 1'b1; req_i = '0;
    tick(); force_irq = 1'b0;
    @(negedge clk); chk_wr("race_clr", 3'd0, 16'h0000);
    to_neg(s + 22); chk("race_done", 32'(done_o), 32'h4); chk("race_nostop", 32'(tmr_chipselect_o), 32'h0);
    to_neg(s + 23); chk("race_idle", 32'(busy_o), 32'h0);

    // Reset mid-WAIT, then a fresh grant
    start(1, 32'd1000, s);
    to_neg(s + 29);
    tick(); reset_n = 1'b0; req_i = '0;
    #1;
    chk("reset_async", 32'({grant_o, done_o, busy_o, tmr_chipselect_o, tmr_write_n_o, tmr_address_o, tmr_writedata_o}),
        32'({4'b0, 4'b0, 1'b0, 1'b0, 1'b1, 3'b0, 16'h0}));
    to_neg(s + 32);
    tick(); reset_n = 1'b1;
    start(1, 32'd50, s);
    to_neg(s + 1);  chk("post_rst_grant", 32'(grant_o), 32'h2); chk_wr("post_rst_pl", 3'd2, 16'h0031);
    to_neg(s + 2);  chk_wr("post_rst_ph", 3'd3, 16'h0000);
    to_neg(s + 4);  chk_wr("post_rst_ctl", 3'd1, 16'h0005);
    to_neg(s + 57); chk("post_rst_done", 32'(done_o), 32'h2);
    tick(); req_i = '0;
    repeat (3) tick();
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/nios_sd_loader_timeout_sched.md
# nios_sd_loader_timeout_sched

Hardware timeout scheduler that shares the single system interval timer among several requesters in the SD loader subsystem. It arbitrates one-shot timeout requests round-robin and programs the timer through its Avalon-MM slave port (period, control, status). It waits for the timer interrupt and returns a one-cycle done pulse to the winning requester. Requesters can abort a running timeout by dropping their request.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- req_i  in  NUM_REQ  level request per requester; held until done_o or dropped to abort
- ticks_i  in  32*NUM_REQ  packed timeout length in clk cycles; requester k uses bits [32k+31:32k]
- grant_o  out  NUM_REQ  one-hot, high while requester owns the timer
- done_o  out  NUM_REQ  one-cycle pulse on timeout completion
- busy_o  out  1  high in every state except IDLE
- tmr_address_o  out  3  timer slave word address
- tmr_chipselect_o  out  1  timer slave select
- tmr_write_n_o  out  1  timer slave write strobe, active-low
- tmr_writedata_o  out  16  timer slave write data
- tmr_irq_i  in  1  timer interrupt (status TO && control ITO)

## Operation
- Timer register map: 0 status (any write clears TO), 1 control (bit0 ITO, bit1 CONT, bit2 START, bit3 STOP), 2 period low, 3 period high.
  - A period write forces a reload and stops the counter.
  - A period value P expires P+1 cycles after START.
- Every slave write is a single-cycle access: chipselect=1, write_n=0. The slave has no waitrequest.
- In all other cycles: chipselect=0, write_n=1, address=0, writedata=0.
- Arbitration is round-robin. A pointer holds the last granted index, and the search starts at pointer+1 modulo NUM_REQ. After reset the pointer is NUM_REQ-1, so requester 0 has first priority.
- State machine:
  - IDLE: if any req_i is set, latch the winner index and T=ticks, assert grant_o, and update the pointer. If T=0, go to DONE; otherwise go to WR_PL.
  - WR_PL: write address 2 with (T-1)[15:0], then go to WR_PH.
  - WR_PH: write address 3 with (T-1)[31:16], then go to GAP.
  - GAP: one idle cycle so the timer's force-reload settles. Go to WR_CTL.
  - WR_CTL: write address 1 with 0x0005 (ITO, START, one-shot), then go to WAIT.
  - WAIT: if tmr_irq_i is high, go to CLR. Otherwise, if the owner's req_i is low, go to AB_STOP.
  - CLR: write address 0 with 0x0000, then go to DONE.
  - DONE: pulse done_o[owner] and go to IDLE. grant_o drops on the same cycle.
  - AB_STOP: write address 1 with 0x0008 (STOP, ITO off), then go to AB_CLR.
  - AB_CLR: write address 0 with 0x0000, then go to IDLE with no done pulse.
- In states before WAIT, a dropped req_i is ignored. Abort is checked only in WAIT.
- If irq and req drop occur in the same WAIT cycle, irq wins and done_o is pulsed.
- ticks_i is sampled only in IDLE. Later changes have no effect on the running timeout.
- Arithmetic: T-1 is computed in 32 bits. T=0 never reaches the timer.

## Timing
- Reset values: grant_o=0, done_o=0, busy_o=0, tmr_chipselect_o=0, tmr_write_n_o=1, tmr_address_o=0, tmr_writedata_o=0. State resets to IDLE and the pointer to NUM_REQ-1.
- All outputs are registered. Reset asserted mid-operation returns everything to reset values immediately.
  - The timer shares reset_n and so is also reset.
- Cycle numbering: the IDLE cycle that samples req_i is cycle 0.
  - grant_o is high from cycle 1.
  - Writes occur in cycles 1 (PL), 2 (PH) and 4 (CTL).
- With the standard timer, irq rises in cycle T+5. CLR is in cycle T+6. done_o pulses in cycle T+7.
- For T=0, done_o pulses in cycle 2.
- Back-to-back: after DONE or AB_CLR, the FSM is in IDLE on the next cycle. The minimum gap between grants is one IDLE cycle.
- done_o is high for exactly one cycle. grant_o and done_o are never high for different requesters in the same cycle.

## Test plan
- Single request, with the real timer instantiated: req_i[0]=1, T=100 -> slave writes (2,0x0063), (3,0x0000), (1,0x0005) in cycles 1/2/4, CLR write (0,0x0000) in cycle 106, done_o[0] in cycle 107.
- Contention: req_i=4'b0101 held, T=10 each -> grant order 0, 2, 0, 2. Each done pulse occurs 17 cycles after its IDLE sample.
- T=0 on requester 3 -> no slave writes, done_o[3] in cycle 2, busy_o low in cycle 3.
- Abort: T=1000, req dropped in cycle 50 -> writes (1,0x0008) then (0,0x0000), no done pulse, tmr_irq_i stays 0, IDLE after 2 more cycles.
- Simultaneous irq and req drop in WAIT (forced irq) -> CLR then done_o pulse, no STOP write.
- Reset asserted mid-WAIT -> all outputs at reset values immediately. After release, a new req_i[1] is granted with normal cycle-1 timing.
